// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the RAM slave FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SizeByte    = 3'b000,
        SizeHalf    = 3'b001,
        SizeWord    = 3'b010,
        SizeDword   = 3'b011,
        Size4Word   = 3'b100,
        Size8Word   = 3'b101,
        Size16Word  = 3'b110,
        Size32Word  = 3'b111
    } hsize_e;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StErr1,
        StErr2
    } slave_state_e;

endpackage

// File: rtl/ahb_ram_slave_mem.sv
// Synchronous single-port RAM with per-byte write enables and a registered read port.
module ahb_ram_slave_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                                              clk_i,
    input  logic                                              en_i,
    input  logic [DATA_WIDTH/8-1:0]                           be_i,
    input  logic [((MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]                             wdata_i,
    output logic [DATA_WIDTH-1:0]                             rdata_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // An enabled cycle with no byte enables is a read; the read register holds otherwise.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (|be_i) begin
                for (int i = 0; i < NB; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM slave: configurable wait states, two-cycle ERROR response and a one-entry
// write buffer so a write completing under a pipelined read never collides on the RAM port.
module ahb_ram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [2:0]            hburst,
    input  logic [2:0]            hsize,
    input  logic [1:0]            htrans,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hwrite,
    input  logic                  hready_in,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned BL = $clog2(NB);
    localparam int unsigned WW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned IW = ADDR_WIDTH - BL;

    function automatic logic [NB-1:0] byte_en(input logic [2:0] size, input logic [BL-1:0] lane);
        logic [NB-1:0] mask;
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (32'd1 << size)) begin
                mask[i] = 1'b1;
            end
        end
        return mask << lane;
    endfunction

    slave_state_e          state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  write_q, write_d;
    logic [WW-1:0]         word_q, word_d;
    logic [BL-1:0]         lane_q, lane_d;
    logic [2:0]            size_q, size_d;
    logic                  wbuf_valid_q, wbuf_valid_d;
    logic [WW-1:0]         wbuf_word_q, wbuf_word_d;
    logic [NB-1:0]         wbuf_be_q, wbuf_be_d;
    logic [DATA_WIDTH-1:0] wbuf_data_q, wbuf_data_d;
    logic [NB-1:0]         fwd_be_q, fwd_be_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  accept, illegal, oob, too_big, misalign;
    logic [IW-1:0]         widx;
    logic [BL-1:0]         amask;
    logic                  rd_issue, wr_commit;
    logic [WW-1:0]         rd_word;
    logic [NB-1:0]         wr_be;
    logic                  ram_en;
    logic [NB-1:0]         ram_be;
    logic [WW-1:0]         ram_word;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata, merged;
    logic                  unused_hburst;

    assign unused_hburst = ^hburst;

    assign accept   = hsel && hready_in && ((htrans == TransNonseq) || (htrans == TransSeq));
    assign widx     = haddr[ADDR_WIDTH-1:BL];
    assign oob      = widx >= IW'(MEM_DEPTH);
    assign too_big  = hsize > 3'(BL);
    assign amask    = BL'((32'd1 << hsize) - 32'd1);
    assign misalign = |(haddr[BL-1:0] & amask);
    assign illegal  = oob || too_big || misalign;

    assign wr_commit = (state_q == StIdle) && valid_q && write_q;
    assign wr_be     = byte_en(size_q, lane_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        write_d  = write_q;
        word_d   = word_q;
        lane_d   = lane_q;
        size_d   = size_q;
        hready   = 1'b1;
        hresp    = RespOkay;
        rd_issue = 1'b0;
        rd_word  = word_q;
        unique case (state_q)
            StIdle, StErr2: begin
                hresp   = (state_q == StErr2) ? RespError : RespOkay;
                valid_d = 1'b0;
                state_d = StIdle;
                if (accept) begin
                    write_d = hwrite;
                    word_d  = haddr[BL +: WW];
                    lane_d  = haddr[BL-1:0];
                    size_d  = hsize;
                    if (illegal) begin
                        state_d = StErr1;
                    end else begin
                        valid_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = StWait;
                            cnt_d   = 2'(WAIT_STATES - 1);
                        end else if (!hwrite) begin
                            rd_issue = 1'b1;
                            rd_word  = haddr[BL +: WW];
                        end
                    end
                end
            end
            StWait: begin
                hready = 1'b0;
                if (cnt_q == '0) begin
                    state_d  = StIdle;
                    rd_issue = !write_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StErr1: begin
                hready  = 1'b0;
                hresp   = RespError;
                state_d = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    // Port priority: read issue, then direct write, then buffer drain. A write only has to
    // wait in the buffer when a zero-wait read is accepted on its completion edge.
    always_comb begin
        ram_en       = 1'b0;
        ram_be       = '0;
        ram_word     = rd_word;
        ram_wdata    = hwdata;
        wbuf_valid_d = wbuf_valid_q;
        wbuf_word_d  = wbuf_word_q;
        wbuf_be_d    = wbuf_be_q;
        wbuf_data_d  = wbuf_data_q;
        fwd_be_d     = fwd_be_q;
        fwd_data_d   = fwd_data_q;
        rd_valid_d   = rd_valid_q;
        if (rd_issue) begin
            ram_en = 1'b1;
            if (wr_commit) begin
                wbuf_valid_d = 1'b1;
                wbuf_word_d  = word_q;
                wbuf_be_d    = wr_be;
                wbuf_data_d  = hwdata;
            end
        end else if (wr_commit) begin
            ram_en   = 1'b1;
            ram_be   = wr_be;
            ram_word = word_q;
        end else if (wbuf_valid_q) begin
            ram_en       = 1'b1;
            ram_be       = wbuf_be_q;
            ram_word     = wbuf_word_q;
            ram_wdata    = wbuf_data_q;
            wbuf_valid_d = 1'b0;
        end
        if (rd_issue) begin
            rd_valid_d = 1'b1;
            fwd_data_d = wbuf_data_d;
            fwd_be_d   = (wbuf_valid_d && (wbuf_word_d == rd_word)) ? wbuf_be_d : '0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            write_q      <= 1'b0;
            word_q       <= '0;
            lane_q       <= '0;
            size_q       <= '0;
            wbuf_valid_q <= 1'b0;
            wbuf_word_q  <= '0;
            wbuf_be_q    <= '0;
            wbuf_data_q  <= '0;
            fwd_be_q     <= '0;
            fwd_data_q   <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            write_q      <= write_d;
            word_q       <= word_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_word_q  <= wbuf_word_d;
            wbuf_be_q    <= wbuf_be_d;
            wbuf_data_q  <= wbuf_data_d;
            fwd_be_q     <= fwd_be_d;
            fwd_data_q   <= fwd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    ahb_ram_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk_i   (hclk),
        .en_i    (ram_en),
        .be_i    (ram_be),
        .addr_i  (ram_word),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        merged = ram_rdata;
        for (int i = 0; i < NB; i++) begin
            if (fwd_be_q[i]) begin
                merged[8*i +: 8] = fwd_data_q[8*i +: 8];
            end
        end
        hrdata = rd_valid_q ? merged : '0;
    end

endmodule
